// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, reads a combinational imem and buffers {pc, instr} for decode.
// Optional halt-on-unimp behaviour is enabled with `define FETCH_HALT_ON_UNIMP_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 1024,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign,
   output logic        range_err,
   output logic        halted
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0]   LIMIT   = 32'(IMEM_BYTES);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0]   pc;
   logic [CW-1:0] count;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [31:0]   buf_pc    [FIFO_DEPTH];
   logic [31:0]   buf_instr [FIFO_DEPTH];
   logic          range_cond;
   logic          pop;
   logic          push;
   logic          mis_q;
   logic          range_q;
   logic          halt_q;

   assign imem_addr  = pc;
   assign out_valid  = (count != '0);
   assign out_pc     = buf_pc[rptr];
   assign out_instr  = buf_instr[rptr];
   assign misalign   = mis_q;
   assign range_err  = range_q;
   assign halted     = halt_q;

   assign range_cond = (pc >= LIMIT);
   assign pop        = out_valid & out_ready;
   // A pop frees a slot this cycle, so a full FIFO still accepts a new word.
   assign push       = !redirect_valid & !range_cond & !halt_q & ((count < DEPTH_C) | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         count   <= '0;
         wptr    <= '0;
         rptr    <= '0;
         mis_q   <= 1'b0;
         range_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         // Redirect squashes everything buffered, including a head popped this cycle.
         pc      <= {redirect_pc[31:2], 2'b00};
         count   <= '0;
         wptr    <= '0;
         rptr    <= '0;
         mis_q   <= |redirect_pc[1:0];
         range_q <= 1'b0;
      end else begin
         mis_q <= 1'b0;
         if (range_cond)
            range_q <= 1'b1;
         if (push) begin
            buf_pc[wptr]    <= pc;
            buf_instr[wptr] <= imem_instr;
            wptr            <= wptr + PTR_ONE;
            pc              <= pc + 32'd4;
         end
         if (pop)
            rptr <= rptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (!push && pop)
            count <= count - CNT_ONE;
      end
   end

`ifdef FETCH_HALT_ON_UNIMP_EN
   localparam logic [31:0] UNIMP = 32'hc000_1073;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         halt_q <= 1'b0;
      else if (redirect_valid)
         halt_q <= 1'b0;
      else if (push && (imem_instr == UNIMP))
         halt_q <= 1'b1;
   end
`else
   assign halt_q = 1'b0;
`endif

endmodule
